// File: rtl/demux_pkg.sv
// Shared types and defaults for the sequential 1:N demultiplexer.
package demux_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2
   } demux_state_t;

   localparam int unsigned DEMUX_LANES_DEF   = 8;
   localparam logic [7:0]  DEMUX_RST_VAL_DEF = 8'h00;

endpackage

// File: rtl/demux_lane_dec.sv
// One-hot lane decoder shared by the output write-enable and the fill mask.
module demux_lane_dec #(
   parameter  int unsigned LANES = 8,
   localparam int unsigned SW    = $clog2(LANES)
) (
   input  logic [SW-1:0]    sel,
   output logic [LANES-1:0] onehot
);

   // Set exactly the bit addressed by sel.
   always_comb begin
      onehot      = '0;
      onehot[sel] = 1'b1;
   end

endmodule

// File: rtl/demux1_8_seq.sv
// Sequential 1:N demultiplexer: routes a serial bit into a registered lane,
// addressed by S or by the internal scan counter, and holds each completed
// frame until the consumer acknowledges it.
module demux1_8_seq
   import demux_pkg::*;
#(
   parameter  int unsigned      LANES   = DEMUX_LANES_DEF,
   parameter  logic [LANES-1:0] RST_VAL = LANES'(DEMUX_RST_VAL_DEF),
   localparam int unsigned      SW      = $clog2(LANES)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             D,
   input  logic             VLD,
   output logic             RDY,
   input  logic             MODE,
   input  logic [SW-1:0]    S,
   input  logic             CLR,
   input  logic             ACK,
   output logic [LANES-1:0] O,
   output logic             DONE,
   output logic [SW-1:0]    IDX
);

   localparam logic [SW-1:0] CNT_LAST = SW'(LANES - 1);

   demux_state_t     state, state_nxt;
   logic [SW-1:0]    cnt, cnt_nxt;
   logic [LANES-1:0] mask, mask_nxt;
   logic [LANES-1:0] o_nxt;
   logic [SW-1:0]    lane;
   logic [LANES-1:0] lane_hot;
   logic             frame_done;

   assign lane = MODE ? cnt : S;

   demux_lane_dec #(.LANES(LANES)) u_dec (
      .sel    (lane),
      .onehot (lane_hot)
   );

   // Next-state, datapath update and status outputs; CLR overrides everything.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      mask_nxt   = mask;
      o_nxt      = O;
      frame_done = 1'b0;
      RDY        = (state != HOLD);
      DONE       = (state == HOLD);
      if (CLR) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         mask_nxt  = '0;
         o_nxt     = RST_VAL;
      end else begin
         case (state)
            IDLE, FILL: begin
               if (VLD) begin
                  o_nxt    = (O & ~lane_hot) | (D ? lane_hot : '0);
                  mask_nxt = mask | lane_hot;
                  if (MODE) begin
                     cnt_nxt    = (cnt == CNT_LAST) ? '0 : cnt + SW'(1);
                     frame_done = (cnt == CNT_LAST);
                  end else begin
                     frame_done = &(mask | lane_hot);
                  end
                  state_nxt = frame_done ? HOLD : FILL;
               end
            end
            HOLD: begin
               if (ACK) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
                  mask_nxt  = '0;
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               mask_nxt  = '0;
            end
         endcase
      end
   end

   // State, scan counter, fill mask and lane outputs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
         cnt   <= '0;
         mask  <= '0;
         O     <= RST_VAL;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         mask  <= mask_nxt;
         O     <= o_nxt;
      end
   end

   assign IDX = cnt;

endmodule

// File: tb/tb_demux1_8_seq.sv
// Directed bench for demux1_8_seq with hand-computed expectations.
module tb_demux1_8_seq;

   logic       CLK = 1'b0;
   logic       RST_N, D, VLD, MODE, CLR, ACK;
   logic [2:0] S;
   logic       RDY, DONE;
   logic [7:0] O;
   logic [2:0] IDX;

   int unsigned tests = 0;
   int unsigned fails = 0;

   demux1_8_seq #(.LANES(8), .RST_VAL(8'h00)) dut (
      .CLK  (CLK),
      .RST_N(RST_N),
      .D    (D),
      .VLD  (VLD),
      .RDY  (RDY),
      .MODE (MODE),
      .S    (S),
      .CLR  (CLR),
      .ACK  (ACK),
      .O    (O),
      .DONE (DONE),
      .IDX  (IDX)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic m, input logic [2:0] s, input logic d);
      MODE = m;
      S    = s;
      D    = d;
      VLD  = 1'b1;
      tick();
   endtask

   task automatic release_hold();
      VLD = 1'b0;
      ACK = 1'b1;
      tick();
      ACK = 1'b0;
   endtask

   logic [7:0] pat;
   logic [2:0] sl [9];
   logic       dl [9];

   initial begin
      RST_N = 1'b0; D = 1'b0; VLD = 1'b0; MODE = 1'b0; CLR = 1'b0; ACK = 1'b0; S = '0;
      sl = '{3'd7, 3'd0, 3'd3, 3'd3, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
      dl = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      tick();
      tick();
      chk("rst_o",    32'(O),    32'h00);
      chk("rst_done", 32'(DONE), 32'd0);
      chk("rst_rdy",  32'(RDY),  32'd1);
      chk("rst_idx",  32'(IDX),  32'd0);
      RST_N = 1'b1;
      tick();

      // 1: scan fill 1,0,1,1,0,0,1,0
      pat = 8'h4D;
      for (int i = 0; i < 7; i++) wr(1'b1, 3'd0, pat[i]);
      chk("scan_idx7",  32'(IDX),  32'd7);
      chk("scan_done7", 32'(DONE), 32'd0);
      wr(1'b1, 3'd0, pat[7]);
      chk("scan_o",    32'(O),    32'h4D);
      chk("scan_done", 32'(DONE), 32'd1);
      chk("scan_idx",  32'(IDX),  32'd0);
      chk("scan_rdy",  32'(RDY),  32'd0);

      // 3: VLD ignored in HOLD, then ACK with VLD drops the write
      for (int i = 0; i < 4; i++) wr(1'b0, 3'd0, 1'b0);
      chk("hold_o",    32'(O),    32'h4D);
      chk("hold_done", 32'(DONE), 32'd1);
      chk("hold_rdy",  32'(RDY),  32'd0);
      ACK = 1'b1;
      wr(1'b0, 3'd0, 1'b0);
      ACK = 1'b0;
      VLD = 1'b0;
      chk("ack_o",    32'(O),    32'h4D);
      chk("ack_done", 32'(DONE), 32'd0);
      chk("ack_rdy",  32'(RDY),  32'd1);
      chk("ack_idx",  32'(IDX),  32'd0);

      // 2: addressed out-of-order fill with a lane rewrite
      for (int i = 0; i < 8; i++) wr(1'b0, sl[i], dl[i]);
      chk("addr_done8", 32'(DONE), 32'd0);
      chk("addr_rdy8",  32'(RDY),  32'd1);
      wr(1'b0, sl[8], dl[8]);
      chk("addr_o",    32'(O),    32'hF7);
      chk("addr_done", 32'(DONE), 32'd1);
      chk("addr_idx",  32'(IDX),  32'd0);
      release_hold();

      // 4: CLR mid-frame beats VLD, then a fresh frame (ACK outside HOLD is inert)
      for (int i = 0; i < 5; i++) wr(1'b1, 3'd0, 1'b1);
      chk("clr_pre_idx", 32'(IDX), 32'd5);
      CLR = 1'b1;
      wr(1'b1, 3'd0, 1'b1);
      CLR = 1'b0;
      VLD = 1'b0;
      chk("clr_o",    32'(O),    32'h00);
      chk("clr_idx",  32'(IDX),  32'd0);
      chk("clr_done", 32'(DONE), 32'd0);
      chk("clr_rdy",  32'(RDY),  32'd1);
      pat = 8'hA5;
      for (int i = 0; i < 3; i++) begin
         ACK = (i == 2);
         wr(1'b1, 3'd0, pat[i]);
      end
      ACK = 1'b0;
      chk("ack_fill_idx",  32'(IDX),  32'd3);
      chk("ack_fill_done", 32'(DONE), 32'd0);
      for (int i = 3; i < 7; i++) wr(1'b1, 3'd0, pat[i]);
      chk("clr_frame_done7", 32'(DONE), 32'd0);
      wr(1'b1, 3'd0, pat[7]);
      chk("clr_frame_o",    32'(O),    32'hA5);
      chk("clr_frame_done", 32'(DONE), 32'd1);
      release_hold();

      // 5: asynchronous reset between edges during FILL
      for (int i = 0; i < 3; i++) wr(1'b1, 3'd0, 1'b1);
      VLD = 1'b0;
      chk("arst_pre_o", 32'(O), 32'hA7);
      #3 RST_N = 1'b0;
      #1;
      chk("arst_o",    32'(O),    32'h00);
      chk("arst_done", 32'(DONE), 32'd0);
      chk("arst_idx",  32'(IDX),  32'd0);
      #2 RST_N = 1'b1;
      tick();
      pat = 8'h3C;
      for (int i = 0; i < 8; i++) wr(1'b1, 3'd0, pat[i]);
      chk("arst_frame_o",    32'(O),    32'h3C);
      chk("arst_frame_done", 32'(DONE), 32'd1);
      release_hold();

      // 6: mixed mode, scan lanes 0-3 then addressed lanes 4-7
      wr(1'b1, 3'd0, 1'b1);
      wr(1'b1, 3'd0, 1'b1);
      wr(1'b1, 3'd0, 1'b0);
      wr(1'b1, 3'd0, 1'b0);
      chk("mix_idx4", 32'(IDX), 32'd4);
      wr(1'b0, 3'd4, 1'b1);
      wr(1'b0, 3'd5, 1'b0);
      wr(1'b0, 3'd6, 1'b1);
      chk("mix_done7", 32'(DONE), 32'd0);
      wr(1'b0, 3'd7, 1'b0);
      chk("mix_o",    32'(O),    32'h53);
      chk("mix_done", 32'(DONE), 32'd1);
      chk("mix_idx",  32'(IDX),  32'd4);
      release_hold();
      chk("mix_ack_idx", 32'(IDX), 32'd0);
      for (int i = 0; i < 4; i++) wr(1'b1, 3'd0, 1'b0);
      chk("mix2_idx4",  32'(IDX),  32'd4);
      chk("mix2_done4", 32'(DONE), 32'd0);
      for (int i = 0; i < 3; i++) wr(1'b1, 3'd0, 1'b1);
      chk("mix2_idx7",  32'(IDX),  32'd7);
      chk("mix2_done7", 32'(DONE), 32'd0);
      wr(1'b1, 3'd0, 1'b1);
      VLD = 1'b0;
      chk("mix2_o",    32'(O),    32'hF0);
      chk("mix2_done", 32'(DONE), 32'd1);
      chk("mix2_idx",  32'(IDX),  32'd0);
      release_hold();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
